// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// Controller-to-unit bundle: request fields plus the HI/LO and busy readback.
interface md_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               start;
  logic [MD_OP_W-1:0] op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cancel;
  logic               busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (output start, op, a, b, cancel, input busy, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_calc.sv
// Combinational datapath: signed/unsigned products and truncating division,
// including the divide-by-zero flag and the most-negative / -1 case.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               div_zero
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  // Division runs on magnitudes; signs are restored afterwards so the quotient
  // truncates toward zero and the remainder follows the dividend. The
  // most-negative / -1 quotient wraps back to most-negative on its own.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    is_div   = (op == MD_DIV) || (op == MD_DIVU);
    a_neg    = (op == MD_DIV) && a[WIDTH-1];
    b_neg    = (op == MD_DIV) && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    divisor  = div_zero ? WIDTH'(1) : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;

    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: results are computed at start,
// held as pending, and committed when the fixed busy window expires.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_wr;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (bus.op),
    .a        (bus.a),
    .b        (bus.b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (bus.cancel) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= ST_RUN;
              end
              MD_DIV, MD_DIVU: begin
                // A zero divisor still occupies the full window but commits nothing.
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !div_zero;
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= ST_RUN;
              end
              MD_MTHI: hi_q <= bus.a;
              MD_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios with literal expectations plus random
// traffic, all compared each cycle against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus the result to commit at the end.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwr;
  int          m_rem;

  always @(posedge clk) begin : model
    int     sa, sb;
    longint p;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_rem = 0;
    end else if (bus.cancel) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (bus.start) begin
      sa = bus.a;
      sb = bus.b;
      case (bus.op)
        MD_MULT: begin
          p = longint'(sa) * longint'(sb);
          {m_phi, m_plo} = p;
          m_pwr = 1; m_rem = MC;
        end
        MD_MULTU: begin
          {m_phi, m_plo} = {32'd0, bus.a} * {32'd0, bus.b};
          m_pwr = 1; m_rem = MC;
        end
        MD_DIV: begin
          if (sb == 0) m_pwr = 0;
          else if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 0; m_pwr = 1;
          end else begin
            m_plo = sa / sb; m_phi = sa % sb; m_pwr = 1;
          end
          m_rem = DC;
        end
        MD_DIVU: begin
          if (bus.b == 0) m_pwr = 0;
          else begin
            m_plo = bus.a / bus.b; m_phi = bus.a % bus.b; m_pwr = 1;
          end
          m_rem = DC;
        end
        MD_MTHI: m_hi = bus.a;
        MD_MTLO: m_lo = bus.a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(bus.busy), 32'(m_rem > 0));
      check("model_hi", bus.hi, m_hi);
      check("model_lo", bus.lo, m_lo);
    end
  end

  task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts busy cycles after a start edge; leaves the bench at the first idle negedge.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    pulse(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    pulse(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_hi", bus.hi, 32'd1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    pulse(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    pulse(MD_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    pulse(MD_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    check("divz_cycles", 32'(n), 32'd10);
    check("divz_hi", bus.hi, 32'd2);
    check("divz_lo", bus.lo, 32'd14);

    pulse(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'd0);

    pulse(MD_MTHI, 32'h1234_5678, 32'd0);
    wait_idle(n);
    check("mthi_cycles", 32'(n), 32'd0);
    check("mthi_hi", bus.hi, 32'h1234_5678);

    pulse(MD_MULT, 32'd7, 32'd9);
    pulse(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    check("mtlo_busy_lo", bus.lo, 32'd63);
    check("mtlo_busy_hi", bus.hi, 32'd0);

    pulse(MD_MULT, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk); #1 bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 32'(bus.busy), 32'd0);
    repeat (6) @(negedge clk);
    check("cancel_hi", bus.hi, 32'd0);
    check("cancel_lo", bus.lo, 32'd63);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'hAAAA_AAAA; bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_start_hi", bus.hi, 32'd0);

    pulse(MD_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rst_mid_lo_later", bus.lo, 32'd0);

    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      bus.start  = ($urandom_range(0, 3) != 0);
      bus.op     = 3'($urandom_range(0, 7));
      bus.a      = pick();
      bus.b      = pick();
      bus.cancel = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
    end
    wait_idle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
